// File: rtl/sonic_echo_responder.sv
// Ultrasonic range-sensor emulator: answers a Trig pulse with an Echo pulse
// whose width encodes a programmed target distance.
module sonic_echo_responder #(
    parameter int unsigned CLK_MHZ         = 100,
    parameter int unsigned MIN_TRIG_CYCLES = 10 * CLK_MHZ,
    parameter int unsigned BURST_CYCLES    = 200 * CLK_MHZ,
    parameter int unsigned CYC_PER_CM      = 58 * CLK_MHZ,
    parameter int unsigned MAX_CM          = 400,
    parameter int unsigned TIMEOUT_CYCLES  = 38000 * CLK_MHZ,
    parameter int unsigned HOLDOFF_CYCLES  = 10000 * CLK_MHZ
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trig,
    input  logic [8:0] distance_cm,
    output logic       echo,
    output logic       busy,
    output logic       short_trig
);

    localparam int unsigned MAX_IN_RANGE = MAX_CM * CYC_PER_CM;
    localparam int unsigned MAX_W_A      = (MAX_IN_RANGE > TIMEOUT_CYCLES) ? MAX_IN_RANGE : TIMEOUT_CYCLES;
    localparam int unsigned MAX_WIDTH    = (MAX_W_A > 2 * CYC_PER_CM) ? MAX_W_A : 2 * CYC_PER_CM;
    localparam int unsigned WIDTH_BITS   = $clog2(MAX_WIDTH + 1);
    localparam int unsigned WIDTH_W      = (WIDTH_BITS > 23) ? WIDTH_BITS : 23;
    localparam int unsigned PHASE_A      = (BURST_CYCLES > HOLDOFF_CYCLES) ? BURST_CYCLES : HOLDOFF_CYCLES;
    localparam int unsigned PHASE_MAX    = (PHASE_A > MIN_TRIG_CYCLES) ? PHASE_A : MIN_TRIG_CYCLES;
    localparam int unsigned PHASE_BITS   = $clog2(PHASE_MAX + 1);
    localparam int unsigned CNT_W        = (PHASE_BITS > WIDTH_W) ? PHASE_BITS : WIDTH_W;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TRIG_HI = 3'd1,
        S_BURST   = 3'd2,
        S_ECHO    = 3'd3,
        S_HOLDOFF = 3'd4
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH_W-1:0]   width_q;
    logic [WIDTH_W-1:0]   width_c;
    logic                 trig_meta;
    logic                 trig_s;
    logic                 trig_s_d;
    logic                 sync_vld1;
    logic                 sync_vld2;
    logic                 armed;
    logic                 trig_rise_c;

    // Two-flop synchronizer, edge history, and arming once a real low has been seen
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_meta <= 1'b0;
            trig_s    <= 1'b0;
            trig_s_d  <= 1'b0;
            sync_vld1 <= 1'b0;
            sync_vld2 <= 1'b0;
            armed     <= 1'b0;
        end else begin
            trig_meta <= trig;
            trig_s    <= trig_meta;
            trig_s_d  <= trig_s;
            sync_vld1 <= 1'b1;
            sync_vld2 <= sync_vld1;
            armed     <= armed | (sync_vld2 & ~trig_s);
        end
    end

    // A rising edge only counts after trig has genuinely been observed low
    assign trig_rise_c = trig_s & ~trig_s_d & armed;

    // Echo width for the current distance input (latched at trig acceptance)
    always_comb begin
        width_c = WIDTH_W'(0);
        if (distance_cm == 9'd0) begin
            width_c = WIDTH_W'(2 * CYC_PER_CM);
        end else if (32'(distance_cm) > MAX_CM) begin
            width_c = WIDTH_W'(TIMEOUT_CYCLES);
        end else begin
            width_c = WIDTH_W'(distance_cm) * WIDTH_W'(CYC_PER_CM);
        end
    end

    // Measurement sequencer: trig width check, burst delay, echo, dead time
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= CNT_W'(0);
            width_q    <= WIDTH_W'(0);
            echo       <= 1'b0;
            busy       <= 1'b0;
            short_trig <= 1'b0;
        end else begin
            short_trig <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (trig_rise_c) begin
                        state <= S_TRIG_HI;
                        cnt   <= CNT_W'(1);
                        busy  <= 1'b1;
                    end
                end
                S_TRIG_HI: begin
                    if (trig_s) begin
                        if (cnt < CNT_W'(MIN_TRIG_CYCLES)) begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else if (cnt >= CNT_W'(MIN_TRIG_CYCLES)) begin
                        width_q <= width_c;
                        cnt     <= CNT_W'(0);
                        state   <= S_BURST;
                    end else begin
                        short_trig <= 1'b1;
                        busy       <= 1'b0;
                        cnt        <= CNT_W'(0);
                        state      <= S_IDLE;
                    end
                end
                S_BURST: begin
                    if (cnt == CNT_W'(BURST_CYCLES - 1)) begin
                        cnt   <= CNT_W'(0);
                        echo  <= 1'b1;
                        state <= S_ECHO;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_ECHO: begin
                    if (cnt == CNT_W'(width_q - WIDTH_W'(1))) begin
                        cnt   <= CNT_W'(0);
                        echo  <= 1'b0;
                        state <= S_HOLDOFF;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_HOLDOFF: begin
                    if (cnt == CNT_W'(HOLDOFF_CYCLES - 1)) begin
                        cnt   <= CNT_W'(0);
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= CNT_W'(0);
                    echo  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sonic_echo_responder.sv
// Scoreboard bench for sonic_echo_responder using small timing parameters.
module tb_sonic_echo_responder;

    localparam int MIN_T = 4;
    localparam int BURST = 3;
    localparam int CYC   = 2;
    localparam int MAXC  = 20;
    localparam int TMO   = 100;
    localparam int HOLD  = 5;

    typedef struct {
        int width;
        int rise;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       trig = 1'b0;
    logic [8:0] distance_cm = 9'd0;
    logic       echo;
    logic       busy;
    logic       short_trig;

    exp_t exp_q[$];
    exp_t cur;
    int   cyc       = 0;
    int   n_chk     = 0;
    int   n_pass    = 0;
    int   st_cnt    = 0;
    int   exp_short = 0;
    int   rise_cyc  = 0;
    bit   in_echo   = 1'b0;

    sonic_echo_responder #(
        .CLK_MHZ        (1),
        .MIN_TRIG_CYCLES(MIN_T),
        .BURST_CYCLES   (BURST),
        .CYC_PER_CM     (CYC),
        .MAX_CM         (MAXC),
        .TIMEOUT_CYCLES (TMO),
        .HOLDOFF_CYCLES (HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .trig       (trig),
        .distance_cm(distance_cm),
        .echo       (echo),
        .busy       (busy),
        .short_trig (short_trig)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic int exp_width(input int d);
        if (d == 0) return 2 * CYC;
        if (d > MAXC) return TMO;
        return d * CYC;
    endfunction

    // Drive a trig pulse of len cycles; queue the expected echo if it is long enough
    task automatic pulse(input int len, input int d, input bit expect_echo);
        exp_t e;
        @(negedge clk);
        distance_cm = 9'(d);
        trig = 1'b1;
        repeat (len) @(negedge clk);
        trig = 1'b0;
        if (expect_echo) begin
            e.width = exp_width(d);
            e.rise  = cyc + BURST + 3;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || echo) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("idle_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_echo(input bit val);
        int n = 0;
        while (echo != val && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(val ? "echo_rise_seen" : "echo_fall_seen", int'(echo), int'(val));
    endtask

    // Output monitor: times each echo pulse and pops the scoreboard
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            in_echo = 1'b0;
        end else begin
            if (short_trig) st_cnt++;
            if (echo && !in_echo) begin
                in_echo  = 1'b1;
                rise_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_echo", int'(echo), 0);
                    cur.width = -1;
                end else begin
                    cur = exp_q.pop_front();
                    check("echo_rise_cycle", rise_cyc, cur.rise);
                end
            end else if (!echo && in_echo) begin
                in_echo = 1'b0;
                if (cur.width >= 0) check("echo_width", cyc - rise_cyc, cur.width);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_echo", int'(echo), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_short", int'(short_trig), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Basic widths, including the minimum valid trig and range boundaries
        pulse(6, 10, 1'b1);  wait_idle();
        pulse(MIN_T, 0, 1'b1);  wait_idle();
        pulse(5, MAXC, 1'b1);  wait_idle();
        pulse(5, MAXC + 1, 1'b1);  wait_idle();
        pulse(5, 3, 1'b1);  wait_idle();
        pulse(5, 3, 1'b1);  wait_idle();

        // Trig one cycle too short is rejected
        pulse(MIN_T - 1, 5, 1'b0);
        exp_short++;
        begin
            int n = 0;
            while (!short_trig && n < 8) begin
                @(negedge clk);
                n++;
            end
        end
        check("short_seen", int'(short_trig), 1);
        @(negedge clk);
        check("short_one_cycle", int'(short_trig), 0);
        check("short_busy", int'(busy), 0);
        repeat (3) @(negedge clk);

        // Retrigger and distance change during ECHO have no effect
        pulse(6, MAXC, 1'b1);
        wait_echo(1'b1);
        repeat (5) @(negedge clk);
        distance_cm = 9'd5;
        trig = 1'b1;
        repeat (6) @(negedge clk);
        trig = 1'b0;
        wait_idle();

        // Trig during HOLDOFF, still high when IDLE is reached, is ignored
        pulse(4, 3, 1'b1);
        wait_echo(1'b1);
        wait_echo(1'b0);
        trig = 1'b1;
        repeat (8) @(negedge clk);
        trig = 1'b0;
        wait_idle();
        repeat (10) @(negedge clk);

        // Reset in the middle of ECHO with trig held high through release
        pulse(6, MAXC, 1'b1);
        wait_echo(1'b1);
        repeat (10) @(negedge clk);
        exp_q.delete();
        trig = 1'b1;
        rst  = 1'b1;
        @(negedge clk);
        check("midecho_rst_echo", int'(echo), 0);
        check("midecho_rst_busy", int'(busy), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("held_trig_busy", int'(busy), 0);
        trig = 1'b0;
        repeat (3) @(negedge clk);
        pulse(5, 3, 1'b1);
        wait_idle();

        repeat (10) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        check("short_count", st_cnt, exp_short);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sonic_echo_responder.md
SONIC_ECHO_RESPONDER -- requirements
Module: sonic_echo_responder

Interface
REQ-001 Parameter CLK_MHZ, default 100, clock frequency in MHz.
REQ-002 Parameter MIN_TRIG_CYCLES, default 1000, minimum valid trig high width in cycles (10 us).
REQ-003 Parameter BURST_CYCLES, default 20000, delay from accepted trig to echo rise (200 us).
REQ-004 Parameter CYC_PER_CM, default 5800, echo high cycles per cm (58 us x CLK_MHZ).
REQ-005 Parameter MAX_CM, default 400, largest in-range distance.
REQ-006 Parameter TIMEOUT_CYCLES, default 3800000, echo width for out-of-range distance (38 ms).
REQ-007 Parameter HOLDOFF_CYCLES, default 1000000, dead time after echo fall (10 ms).
REQ-008 clk  input  1  system clock; the single clock; all logic on its rising edge.
REQ-009 rst  input  1  synchronous, active-high reset.
REQ-010 trig  input  1  asynchronous trigger from the ultrasonic driver (its Trig output).
REQ-011 distance_cm  input  9  emulated target distance in cm, sampled once per measurement.
REQ-012 echo  output  1  registered echo pulse returned to the driver's Echo input.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 short_trig  output  1  one-cycle pulse flagging a rejected trig that was too short.

Function
REQ-015 trig SHALL pass through a 2-FF synchronizer (trig_s); a rising edge is trig_s=1 with its previous registered value 0.
REQ-016 The FSM SHALL have states IDLE, TRIG_HI, BURST, ECHO, HOLDOFF.
REQ-017 IDLE: a trig_s rising edge SHALL move to TRIG_HI with the width counter at 1; trig already high on entry to IDLE SHALL NOT start a measurement.
REQ-018 TRIG_HI: the counter SHALL increment each cycle trig_s=1 and saturate at MIN_TRIG_CYCLES.
REQ-019 On trig_s falling with count >= MIN_TRIG_CYCLES, the FSM SHALL latch distance_cm, compute the echo width, and enter BURST.
REQ-020 On trig_s falling with count < MIN_TRIG_CYCLES, the FSM SHALL pulse short_trig for exactly one cycle and return to IDLE.
REQ-021 Echo width: latched distance 0 -> 2*CYC_PER_CM; 1..MAX_CM -> distance*CYC_PER_CM; >MAX_CM -> TIMEOUT_CYCLES.
REQ-022 Echo width SHALL be computed and registered at latch time in an unsigned register of at least 23 bits, with no truncation.
REQ-023 BURST SHALL last exactly BURST_CYCLES cycles with echo=0, then enter ECHO.
REQ-024 In ECHO, echo SHALL be 1 for exactly the computed width in cycles, then go to 0 and the FSM SHALL enter HOLDOFF.
REQ-025 HOLDOFF SHALL last exactly HOLDOFF_CYCLES cycles with echo=0 and busy=1, then return to IDLE.
REQ-026 trig activity in BURST, ECHO and HOLDOFF SHALL be ignored and SHALL NOT extend or restart any phase.
REQ-027 distance_cm changes after latch SHALL NOT affect the current echo.
REQ-028 Echo rise SHALL occur exactly BURST_CYCLES+1 cycles after the cycle trig_s is first seen low in TRIG_HI.

Reset
REQ-029 When rst=1 at a clock edge: state=IDLE, all counters, synchronizer FFs and latched width=0, echo=0, busy=0, short_trig=0, including mid-ECHO and mid-HOLDOFF.
REQ-030 After reset, trig held high SHALL NOT start a measurement until it is seen low and then high again.

Verification
REQ-031 Default parameters: trig high 1200 cycles, distance_cm=10 -> echo rises BURST_CYCLES+1 cycles after trig_s falls; width 58000 cycles; then busy for 1000000 more cycles.
REQ-032 trig high 500 cycles -> short_trig high for 1 cycle, echo stays 0, busy=0 within 2 cycles.
REQ-033 distance_cm=0 -> width 11600 cycles; distance_cm=401 -> width 3800000 cycles; distance_cm=400 -> width 2320000 cycles.
REQ-034 Second valid trig during ECHO, and distance_cm changed 10->50 mid-ECHO -> width stays 58000 cycles and there is no second echo.
REQ-035 rst asserted 100 cycles into ECHO -> echo=0 on the next edge, busy=0; trig already high at release -> no echo until a new rising edge.
REQ-036 Small parameters (MIN_TRIG=4, BURST=3, CYC_PER_CM=2, HOLDOFF=5), back-to-back trigs at distance_cm=3 -> each echo is exactly 6 cycles; a trig during HOLDOFF is ignored.
